// File: rtl/hub_block_tx_if.sv
// Hub block transmit bus between the block sender and its consumer.
// Carries one quadlet per valid/ready handshake.
interface hub_block_tx_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_addr;
    logic [31:0] tx_data;
    logic        tx_last;

    modport master (
        output tx_valid, tx_addr, tx_data, tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_valid, tx_addr, tx_data, tx_last,
        output tx_ready
    );
endinterface

// File: rtl/hub_block_tx.sv
// Broadcasts this board's real-time block to the hub, one quadlet at a time.
// Header is built internally; later quadlets come from a 1-cycle-latency source.
module hub_block_tx #(
    parameter int USE_FW    = 1,
    parameter int MAX_QUADS = 64
) (
    input  logic           sysclk,
    input  logic           reset,
    input  logic           write_trig,
    output logic           write_trig_reset,
    input  logic [15:0]    sequence_i,
    input  logic [3:0]     board_id,
    input  logic [7:0]     blk_size,
    output logic [7:0]     src_raddr,
    input  logic [31:0]    src_rdata,
    output logic           busy,
    output logic           done,
    output logic           size_err,
    hub_block_tx_if.master tx
);

    localparam logic [8:0] MaxQ = 9'(MAX_QUADS);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        FETCH,
        WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  raddr_q, raddr_d;
    logic [7:0]  size_q, size_d;
    logic [15:0] seq_q, seq_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] data_q, data_d;
    logic        wtr_q, wtr_d;
    logic        serr_q, serr_d;

    logic trig;
    logic size_ok;
    logic last;

    // The requester only drops write_trig after seeing the acknowledge,
    // so a trigger is not re-sampled in the cycle the acknowledge is out.
    assign trig    = (USE_FW != 0) && write_trig && !wtr_q;
    assign size_ok = (blk_size >= 8'd3) && ({1'b0, blk_size} <= MaxQ);
    assign last    = (idx_q == size_q - 8'd1);

    // Next-state, latching and datapath selection
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        raddr_d = raddr_q;
        size_d  = size_q;
        seq_d   = seq_q;
        id_d    = id_q;
        data_d  = data_q;
        wtr_d   = 1'b0;
        serr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    wtr_d = 1'b1;
                    if (size_ok) begin
                        seq_d   = sequence_i;
                        id_d    = board_id;
                        size_d  = blk_size;
                        idx_d   = 8'd0;
                        data_d  = {sequence_i, 8'd0, blk_size};
                        state_d = SEND;
                    end else begin
                        serr_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tx.tx_ready) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        raddr_d = idx_q + 8'd1;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                data_d = src_rdata;
                if (idx_q == 8'd2) begin
                    data_d[27:24] = id_q;
                end
                state_d = SEND;
            end
            DONE: begin
                idx_d   = 8'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            raddr_q <= 8'd0;
            size_q  <= 8'd0;
            seq_q   <= 16'd0;
            id_q    <= 4'd0;
            data_q  <= 32'd0;
            wtr_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            raddr_q <= raddr_d;
            size_q  <= size_d;
            seq_q   <= seq_d;
            id_q    <= id_d;
            data_q  <= data_d;
            wtr_q   <= wtr_d;
            serr_q  <= serr_d;
        end
    end

    assign tx.tx_valid      = (state_q == SEND);
    assign tx.tx_addr       = {8'h10, idx_q};
    assign tx.tx_data       = data_q;
    assign tx.tx_last       = last;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign size_err         = serr_q;
    assign write_trig_reset = wtr_q;
    assign src_raddr        = raddr_q;

endmodule
